// File: rtl/dispatch_buffer.sv
// ---------------------------------------------------------------------------
// dispatch_buffer
//
// Decouples the decode stage from the issue queue. Decode delivers groups of
// 1..4 entries; they are parked in an 8-entry circular FIFO and drained into
// the issue queue at up to 4 entries per cycle, limited by the free space the
// issue queue reports (15 usable slots). Drain is strictly in order and an
// accepted group is first visible on the issue-queue side one cycle after it
// is accepted (no same-cycle bypass).
//
// Handshake: a decode group transfers on a rising clk edge when dec_valid and
// dec_ready are both high and dec_count is 1..4. dec_ready does not depend on
// dec_valid, so the producer may hold dec_valid and its group steady until
// dec_ready is seen high. The issue-queue side has no back-pressure of its
// own: every lane below iq_in_data_number is consumed at the next edge.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   dec_valid           decode group valid
//   dec_count[2:0]      valid lanes in dec_data (legal 1..4)
//   dec_data            4 lanes of ELEM_W bits, lane 0 in the low bits
//   dec_ready           buffer can take a full 4-lane group this cycle
//   flush               synchronous discard of all buffered entries
//   iq_size[3:0]        issue-queue occupancy 0..15
//   iq_in_data          entries pushed to the issue queue, lane 0 oldest
//   iq_in_data_number   number of valid lanes in iq_in_data (0..4)
//   err_count           sticky: dec_valid seen with an illegal dec_count
//   stall_cycles[15:0]  saturating count of cycles holding entries but
//                       pushing none
// ---------------------------------------------------------------------------
module dispatch_buffer #(
  parameter int ELEM_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dec_valid,
  input  logic [2:0]          dec_count,
  input  logic [4*ELEM_W-1:0] dec_data,
  output logic                dec_ready,
  input  logic                flush,
  input  logic [3:0]          iq_size,
  output logic [4*ELEM_W-1:0] iq_in_data,
  output logic [2:0]          iq_in_data_number,
  output logic                err_count,
  output logic [15:0]         stall_cycles
);

  logic [ELEM_W-1:0] mem_q [8];

  logic [2:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  wr_ptr_q, wr_ptr_d;
  logic [3:0]  count_q, count_d;
  logic        err_q, err_d;
  logic [15:0] stall_q, stall_d;

  logic        count_legal;
  logic        accept;
  logic [3:0]  acc_num;
  logic [3:0]  free_slots;
  logic [3:0]  drain_n;

  always_comb begin
    count_legal = (dec_count != 3'd0) && (dec_count <= 3'd4);
    // Ready only when a full 4-lane group is guaranteed to fit in 8 slots.
    dec_ready   = (count_q <= 4'd4) && !flush;
    accept      = dec_valid && dec_ready && count_legal;
    acc_num     = accept ? {1'b0, dec_count} : 4'd0;
    free_slots  = 4'd15 - iq_size;

    // n = min(count, 4, free); flush suppresses any push.
    drain_n = count_q;
    if (drain_n > 4'd4)       drain_n = 4'd4;
    if (free_slots < drain_n) drain_n = free_slots;
    if (flush)                drain_n = 4'd0;

    // Lanes at or beyond n are forced to zero rather than showing stale data.
    iq_in_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (4'(i) < drain_n) begin
        iq_in_data[i*ELEM_W +: ELEM_W] = mem_q[rd_ptr_q + 3'(i)];
      end
    end
    iq_in_data_number = drain_n[2:0];

    // Flush wins over everything; dec_ready is low during flush so nothing
    // can be accepted in the same cycle anyway.
    if (flush) begin
      rd_ptr_d = 3'd0;
      wr_ptr_d = 3'd0;
      count_d  = 4'd0;
    end else begin
      rd_ptr_d = rd_ptr_q + drain_n[2:0];
      wr_ptr_d = wr_ptr_q + acc_num[2:0];
      count_d  = count_q + acc_num - drain_n;
    end

    // Illegal counts are flagged whether or not the buffer was ready.
    err_d = err_q | (dec_valid & ~count_legal);

    stall_d = stall_q;
    if ((count_q != 4'd0) && (drain_n == 4'd0) && !flush && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= 3'd0;
      wr_ptr_q <= 3'd0;
      count_q  <= 4'd0;
      err_q    <= 1'b0;
      stall_q  <= 16'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      stall_q  <= stall_d;
    end
  end

  // Storage is not reset: emptiness is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < dec_count) begin
          mem_q[wr_ptr_q + 3'(i)] <= dec_data[i*ELEM_W +: ELEM_W];
        end
      end
    end
  end

  assign err_count    = err_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_dispatch_buffer.sv
module tb_dispatch_buffer;
  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic           dec_valid;
  logic [2:0]     dec_count;
  logic [4*W-1:0] dec_data;
  logic           dec_ready;
  logic           flush;
  logic [3:0]     iq_size;
  logic [4*W-1:0] iq_in_data;
  logic [2:0]     iq_in_data_number;
  logic           err_count;
  logic [15:0]    stall_cycles;

  dispatch_buffer #(.ELEM_W(W)) dut (
    .clk               (clk),
    .rst               (rst),
    .dec_valid         (dec_valid),
    .dec_count         (dec_count),
    .dec_data          (dec_data),
    .dec_ready         (dec_ready),
    .flush             (flush),
    .iq_size           (iq_size),
    .iq_in_data        (iq_in_data),
    .iq_in_data_number (iq_in_data_number),
    .err_count         (err_count),
    .stall_cycles      (stall_cycles)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic         m_err;
  logic [15:0]  m_stall;
  int           errors = 0;
  int           checks = 0;
  int           seq    = 0;

  function automatic int exp_n();
    int n;
    n = exp_q.size();
    if (n > 4) n = 4;
    if (n > 15 - int'(iq_size)) n = 15 - int'(iq_size);
    if (flush) n = 0;
    return n;
  endfunction

  function automatic logic exp_ready();
    return (exp_q.size() <= 4) && !flush;
  endfunction

  function automatic logic [W-1:0] exp_lane(int i);
    if (i < exp_n()) return exp_q[i];
    return '0;
  endfunction

  function automatic logic [4*W-1:0] make_group();
    logic [4*W-1:0] g;
    for (int i = 0; i < 4; i++) begin
      g[i*W +: W] = {8'hA5, 24'(seq)};
      seq++;
    end
    return g;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [2:0] c, input logic [4*W-1:0] d,
                       input logic [3:0] iq, input logic fl);
    dec_valid = v;
    dec_count = c;
    dec_data  = d;
    iq_size   = iq;
    flush     = fl;
    #1;
  endtask

  // Advance one clock edge and move the reference model with it.
  task automatic commit();
    int n;
    logic acc;
    n   = exp_n();
    acc = dec_valid && (dec_count >= 3'd1) && (dec_count <= 3'd4) && exp_ready();
    if (dec_valid && !((dec_count >= 3'd1) && (dec_count <= 3'd4))) m_err = 1'b1;
    if ((exp_q.size() > 0) && (n == 0) && !flush && (m_stall != 16'hFFFF)) m_stall++;
    if (flush) begin
      exp_q.delete();
    end else begin
      repeat (n) void'(exp_q.pop_front());
      if (acc) begin
        for (int i = 0; i < int'(dec_count); i++) exp_q.push_back(dec_data[i*W +: W]);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 3'd0, '0, 4'd0, 1'b0);
    exp_q.delete();
    m_err   = 1'b0;
    m_stall = 16'd0;
    repeat (2) @(negedge clk);
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", dec_ready); end
    checks++; if (iq_in_data_number !== 3'd0) begin errors++; $display("FAIL reset_number got=%0d exp=0", iq_in_data_number); end
    checks++; if (iq_in_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", iq_in_data); end
    checks++; if (err_count !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_count); end
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", stall_cycles); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (dec_ready !== 1'b1 || iq_in_data_number !== 3'd0) begin
      errors++; $display("FAIL post_reset got ready=%b num=%0d exp ready=1 num=0", dec_ready, iq_in_data_number);
    end
  endtask

  // One accepted group of four drains as a whole the next cycle.
  task automatic test_basic();
    logic [4*W-1:0] g;
    g = make_group();
    drive(1'b1, 3'd4, g, 4'd0, 1'b0);
    checks++; if (iq_in_data_number !== 3'd0) begin errors++; $display("FAIL basic_no_bypass got=%0d exp=0", iq_in_data_number); end
    commit();
    drive(1'b0, 3'd0, '0, 4'd0, 1'b0);
    checks++; if (iq_in_data_number !== 3'd4) begin errors++; $display("FAIL basic_number got=%0d exp=4", iq_in_data_number); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (iq_in_data[i*W +: W] !== g[i*W +: W]) begin
        errors++; $display("FAIL basic_lane%0d got=%h exp=%h", i, iq_in_data[i*W +: W], g[i*W +: W]);
      end
    end
    commit();
    checks++; if (iq_in_data_number !== 3'd0 || exp_q.size() != 0) begin
      errors++; $display("FAIL basic_empty got=%0d exp=0", iq_in_data_number);
    end
  endtask

  // Partial drain limited by issue-queue space, then a full issue queue stalls.
  task automatic test_partial_stall();
    logic [15:0] s0;
    drive(1'b1, 3'd4, make_group(), 4'd15, 1'b0); commit();
    drive(1'b1, 3'd2, make_group(), 4'd15, 1'b0);
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL partial_ready4 got=%b exp=1", dec_ready); end
    commit();
    drive(1'b0, 3'd0, '0, 4'd13, 1'b0);
    checks++; if (iq_in_data_number !== 3'd2) begin errors++; $display("FAIL partial_number got=%0d exp=2", iq_in_data_number); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (iq_in_data[i*W +: W] !== exp_lane(i)) begin
        errors++; $display("FAIL partial_lane%0d got=%h exp=%h", i, iq_in_data[i*W +: W], exp_lane(i));
      end
    end
    commit();
    s0 = stall_cycles;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 3'd0, '0, 4'd15, 1'b0);
      checks++; if (iq_in_data_number !== 3'd0) begin errors++; $display("FAIL stall_number got=%0d exp=0", iq_in_data_number); end
      checks++; if (stall_cycles !== m_stall) begin errors++; $display("FAIL stall_count got=%0d exp=%0d", stall_cycles, m_stall); end
      commit();
    end
    checks++; if (stall_cycles !== s0 + 16'd3) begin errors++; $display("FAIL stall_delta got=%0d exp=%0d", stall_cycles, s0 + 16'd3); end
    while (exp_q.size() > 0) begin
      drive(1'b0, 3'd0, '0, 4'd0, 1'b0);
      checks++; if (iq_in_data_number !== 3'(exp_n())) begin errors++; $display("FAIL partial_drain_num got=%0d exp=%0d", iq_in_data_number, exp_n()); end
      for (int i = 0; i < 4; i++) begin
        checks++; if (iq_in_data[i*W +: W] !== exp_lane(i)) begin
          errors++; $display("FAIL partial_drain_lane%0d got=%h exp=%h", i, iq_in_data[i*W +: W], exp_lane(i));
        end
      end
      commit();
    end
  endtask

  // count=5 deasserts ready; a held group must not be taken.
  task automatic test_backpressure();
    drive(1'b1, 3'd4, make_group(), 4'd15, 1'b0); commit();
    drive(1'b1, 3'd1, make_group(), 4'd15, 1'b0); commit();
    drive(1'b1, 3'd4, make_group(), 4'd15, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got=%b exp=0", dec_ready); end
      checks++; if (iq_in_data_number !== 3'd0) begin errors++; $display("FAIL bp_number got=%0d exp=0", iq_in_data_number); end
      commit();
      #1;
    end
    while (exp_q.size() > 0) begin
      drive(1'b0, 3'd0, '0, 4'd0, 1'b0);
      checks++; if (iq_in_data_number !== 3'(exp_n())) begin errors++; $display("FAIL bp_drain_num got=%0d exp=%0d", iq_in_data_number, exp_n()); end
      for (int i = 0; i < 4; i++) begin
        checks++; if (iq_in_data[i*W +: W] !== exp_lane(i)) begin
          errors++; $display("FAIL bp_drain_lane%0d got=%h exp=%h", i, iq_in_data[i*W +: W], exp_lane(i));
        end
      end
      commit();
    end
  endtask

  // Continuous groups of 3 walk the pointers across the 7->0 wrap repeatedly.
  task automatic test_wrap();
    for (int k = 0; k < 13; k++) begin
      if (k < 10) drive(1'b1, 3'd3, make_group(), 4'd0, 1'b0);
      else        drive(1'b0, 3'd0, '0, 4'd0, 1'b0);
      checks++; if (dec_ready !== exp_ready()) begin errors++; $display("FAIL wrap_ready got=%b exp=%b", dec_ready, exp_ready()); end
      checks++; if (iq_in_data_number !== 3'(exp_n())) begin errors++; $display("FAIL wrap_number got=%0d exp=%0d", iq_in_data_number, exp_n()); end
      for (int i = 0; i < 4; i++) begin
        checks++; if (iq_in_data[i*W +: W] !== exp_lane(i)) begin
          errors++; $display("FAIL wrap_lane%0d got=%h exp=%h", i, iq_in_data[i*W +: W], exp_lane(i));
        end
      end
      commit();
    end
    checks++; if (exp_q.size() != 0 || iq_in_data_number !== 3'd0) begin
      errors++; $display("FAIL wrap_empty got=%0d exp=0", iq_in_data_number);
    end
  endtask

  // Flush drops buffered data and a concurrent group; illegal count sets err.
  task automatic test_flush_err();
    drive(1'b1, 3'd4, make_group(), 4'd15, 1'b0); commit();
    drive(1'b1, 3'd2, make_group(), 4'd15, 1'b0); commit();
    drive(1'b1, 3'd4, make_group(), 4'd0, 1'b1);
    checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", dec_ready); end
    checks++; if (iq_in_data_number !== 3'd0) begin errors++; $display("FAIL flush_number got=%0d exp=0", iq_in_data_number); end
    commit();
    drive(1'b0, 3'd0, '0, 4'd0, 1'b0);
    checks++; if (iq_in_data_number !== 3'd0 || dec_ready !== 1'b1) begin
      errors++; $display("FAIL flush_cleared got num=%0d ready=%b exp num=0 ready=1", iq_in_data_number, dec_ready);
    end
    checks++; if (err_count !== 1'b0) begin errors++; $display("FAIL err_pre got=%b exp=0", err_count); end
    drive(1'b1, 3'd5, make_group(), 4'd0, 1'b0); commit();
    drive(1'b0, 3'd0, '0, 4'd0, 1'b0);
    checks++; if (err_count !== 1'b1) begin errors++; $display("FAIL err_set got=%b exp=1", err_count); end
    checks++; if (iq_in_data_number !== 3'd0) begin errors++; $display("FAIL err_nowrite got=%0d exp=0", iq_in_data_number); end
    drive(1'b0, 3'd0, '0, 4'd0, 1'b1); commit();
    drive(1'b1, 3'd2, make_group(), 4'd0, 1'b0); commit();
    drive(1'b0, 3'd0, '0, 4'd0, 1'b0);
    checks++; if (err_count !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err_count); end
    checks++; if (iq_in_data_number !== 3'd2) begin errors++; $display("FAIL post_flush_num got=%0d exp=2", iq_in_data_number); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (iq_in_data[i*W +: W] !== exp_lane(i)) begin
        errors++; $display("FAIL post_flush_lane%0d got=%h exp=%h", i, iq_in_data[i*W +: W], exp_lane(i));
      end
    end
    commit();
  endtask

  task automatic test_random();
    logic       v, fl;
    logic [2:0] c;
    for (int k = 0; k < 80; k++) begin
      v  = 1'($urandom_range(0, 1));
      c  = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(1, 4));
      fl = ($urandom_range(0, 19) == 0);
      drive(v, c, make_group(), 4'($urandom_range(0, 15)), fl);
      checks++; if (dec_ready !== exp_ready()) begin errors++; $display("FAIL rand_ready got=%b exp=%b", dec_ready, exp_ready()); end
      checks++; if (iq_in_data_number !== 3'(exp_n())) begin errors++; $display("FAIL rand_number got=%0d exp=%0d", iq_in_data_number, exp_n()); end
      for (int i = 0; i < 4; i++) begin
        checks++; if (iq_in_data[i*W +: W] !== exp_lane(i)) begin
          errors++; $display("FAIL rand_lane%0d got=%h exp=%h", i, iq_in_data[i*W +: W], exp_lane(i));
        end
      end
      checks++; if (err_count !== m_err || stall_cycles !== m_stall) begin
        errors++; $display("FAIL rand_status got err=%b stall=%0d exp err=%b stall=%0d", err_count, stall_cycles, m_err, m_stall);
      end
      commit();
    end
  endtask

  // Reset asserted between edges clears state immediately.
  task automatic test_reset_midop();
    drive(1'b1, 3'd4, make_group(), 4'd15, 1'b0); commit();
    drive(1'b0, 3'd0, '0, 4'd15, 1'b0); commit();
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    m_err   = 1'b0;
    m_stall = 16'd0;
    drive(1'b0, 3'd0, '0, 4'd0, 1'b0);
    checks++; if (iq_in_data_number !== 3'd0 || dec_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_outputs got num=%0d ready=%b exp num=0 ready=1", iq_in_data_number, dec_ready);
    end
    checks++; if (err_count !== 1'b0 || stall_cycles !== 16'd0) begin
      errors++; $display("FAIL midrst_status got err=%b stall=%0d exp err=0 stall=0", err_count, stall_cycles);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 3'd3, make_group(), 4'd0, 1'b0); commit();
    drive(1'b0, 3'd0, '0, 4'd0, 1'b0);
    checks++; if (iq_in_data_number !== 3'd3) begin errors++; $display("FAIL midrst_restart got=%0d exp=3", iq_in_data_number); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (iq_in_data[i*W +: W] !== exp_lane(i)) begin
        errors++; $display("FAIL midrst_lane%0d got=%h exp=%h", i, iq_in_data[i*W +: W], exp_lane(i));
      end
    end
    commit();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_partial_stall();
    test_backpressure();
    test_wrap();
    test_flush_err();
    test_random();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
